// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-Lite slave over a word-addressed SRAM with configurable read latency.
// Define AXI_SRAM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axi_sram_slave #(
    parameter int                   ADDR_BITS   = 32,
    parameter int                   DATA_BITS   = 32,
    parameter int                   DEPTH_WORDS = 16384,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0,
    parameter int                   RD_LATENCY  = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [ADDR_BITS-1:0]   ARADDR,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [DATA_BITS-1:0]   RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY,
    input  logic [ADDR_BITS-1:0]   AWADDR,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [DATA_BITS-1:0]   WDATA,
    input  logic [DATA_BITS/8-1:0] WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY
);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int OFF_BITS = $clog2(STRB_BITS);
    localparam int IDX_BITS = $clog2(DEPTH_WORDS);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_RESP} wstate_t;

    logic [DATA_BITS-1:0] mem [DEPTH_WORDS];
    rstate_t rstate, rstate_nx;
    wstate_t wstate, wstate_nx;
    logic [2:0] rcnt;
    logic [IDX_BITS-1:0] r_idx, aw_idx;
    logic [DATA_BITS-1:0] w_data, rd_word;
    logic [STRB_BITS-1:0] w_strb;
    logic [ADDR_BITS-1:0] ar_off, aw_off;
    logic aw_full, w_full, r_oor, aw_oor, ar_oor_in, aw_oor_in;
    logic ar_hs, aw_hs, w_hs, r_sample, wr_en;

    assign ar_off = ARADDR - BASE_ADDR;
    assign aw_off = AWADDR - BASE_ADDR;
`ifdef AXI_SRAM_SLVERR_EN
    assign ar_oor_in = {1'b0, ar_off} >= (ADDR_BITS+1)'(DEPTH_WORDS * STRB_BITS);
    assign aw_oor_in = {1'b0, aw_off} >= (ADDR_BITS+1)'(DEPTH_WORDS * STRB_BITS);
`else
    assign ar_oor_in = 1'b0;
    assign aw_oor_in = 1'b0;
`endif

    assign ar_hs = ARVALID && ARREADY;
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs = WVALID && WREADY;
    assign r_sample = (rstate == R_WAIT) && (rcnt == 3'd0);
    assign wr_en = (wstate == W_EXEC) && !aw_oor;

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            rstate <= R_IDLE;
            wstate <= W_COLLECT;
        end else begin
            rstate <= rstate_nx;
            wstate <= wstate_nx;
        end

    always_comb begin
        rstate_nx = (rstate == R_IDLE) ? (ARVALID ? R_WAIT : R_IDLE) :
                    (rstate == R_WAIT) ? ((rcnt == 3'd0) ? R_RESP : R_WAIT) :
                    (RREADY ? R_IDLE : R_RESP);
        wstate_nx = (wstate == W_COLLECT) ? ((aw_full && w_full) ? W_EXEC : W_COLLECT) :
                    (wstate == W_EXEC) ? W_RESP :
                    (BREADY ? W_COLLECT : W_RESP);
    end

    always_comb begin
        ARREADY = rstate == R_IDLE;
        RVALID = rstate == R_RESP;
        AWREADY = (wstate == W_COLLECT) && !aw_full;
        WREADY = (wstate == W_COLLECT) && !w_full;
        BVALID = wstate == W_RESP;
        BRESP = (BVALID && aw_oor) ? SLVERR : OKAY;
    end

    // Write-first: a same-cycle commit to the sampled word is merged into the read result.
    always_comb begin
        rd_word = mem[r_idx];
        for (int i = 0; i < STRB_BITS; i++)
            if (wr_en && aw_idx == r_idx && w_strb[i]) rd_word[8*i +: 8] = w_data[8*i +: 8];
    end

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            rcnt <= '0;
            r_idx <= '0;
            r_oor <= 1'b0;
            RDATA <= '0;
            RRESP <= OKAY;
        end else begin
            if (ar_hs) begin
                rcnt <= 3'(RD_LATENCY);
                r_idx <= IDX_BITS'(ar_off >> OFF_BITS);
                r_oor <= ar_oor_in;
            end else if (rstate == R_WAIT && rcnt != 3'd0) rcnt <= rcnt - 3'd1;
            if (r_sample) begin
                RDATA <= r_oor ? '0 : rd_word;
                RRESP <= r_oor ? SLVERR : OKAY;
            end
        end

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            aw_full <= 1'b0;
            w_full <= 1'b0;
            aw_idx <= '0;
            aw_oor <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx <= IDX_BITS'(aw_off >> OFF_BITS);
                aw_oor <= aw_oor_in;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (BVALID && BREADY) begin
                aw_full <= 1'b0;
                w_full <= 1'b0;
            end
        end

    always_ff @(posedge ACLK)
        for (int i = 0; i < STRB_BITS; i++)
            if (wr_en && w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed checks of latency, strobes, backpressure, collision, range and reset.
module tb_axi_sram_slave;
    localparam int LAT = 2;
    localparam int DEPTH = 256;

    logic ACLK = 1'b0, ARESETn;
    logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
    logic [3:0] WSTRB;
    logic [1:0] RRESP, BRESP;
    logic ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    int n_checks = 0, n_fail = 0;

    axi_sram_slave #(.ADDR_BITS(32), .DATA_BITS(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
                     .RD_LATENCY(LAT)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit done);
        logic aw_go, w_go;
        done = 1'b0;
        resp = 2'bxx;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
            aw_go = AWREADY;
            w_go = WREADY;
            tick;
            if (aw_go) AWVALID = 1'b0;
            if (w_go) WVALID = 1'b0;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (BVALID) begin
                resp = BRESP;
                done = 1'b1;
            end
            tick;
        end
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
        bit go;
        go = 1'b0;
        lat = -1;
        data = 'x;
        resp = 'x;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < 20 && !go; i++) begin
            go = ARREADY;
            tick;
        end
        ARVALID = 1'b0;
        for (int i = 1; i <= 20 && go && lat < 0; i++) begin
            tick;
            if (RVALID) begin
                lat = i;
                data = RDATA;
                resp = RRESP;
            end
        end
        tick;
        RREADY = 1'b0;
    endtask

    task automatic test_reset;
        ARESETn = 1'b1;
        ARVALID = 1'b0; RREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; AWADDR = '0; WDATA = '0; WSTRB = '0;
        #2 ARESETn = 1'b0;
        tick;
        tick;
        n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", RVALID); end
        n_checks++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b expected 0", BVALID); end
        n_checks++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", RDATA); end
        n_checks++; if (RRESP !== 2'b00 || BRESP !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b/%b expected 00/00", RRESP, BRESP); end
        n_checks++; if ({ARREADY, AWREADY, WREADY} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", {ARREADY, AWREADY, WREADY}); end
        ARESETn = 1'b1;
        tick;
    endtask

    task automatic test_read_latency;
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        int lat;
        do_write(32'h8, 32'hDEADBEEF, 4'hF, r, ok);
        n_checks++; if (!ok || r !== 2'b00) begin n_fail++; $display("FAIL prefill_bresp: got done=%0d resp=%b expected done=1 resp=00", ok, r); end
        do_read(32'h8, d, r, lat);
        n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", d); end
        n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL rd_resp: got %b expected 00", r); end
    endtask

    task automatic test_write_strobe;
        logic [31:0] d;
        logic [1:0] r;
        bit ok, seen;
        int lat;
        do_write(32'h4, 32'h11223344, 4'hF, r, ok);
        AWADDR = 32'h4; AWVALID = 1'b1; BREADY = 1'b0;
        tick;
        AWVALID = 1'b0;
        n_checks++; if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin n_fail++; $display("FAIL aw_held_ready: got aw=%b w=%b expected aw=0 w=1", AWREADY, WREADY); end
        tick;
        tick;
        WDATA = 32'hAABBCCDD; WSTRB = 4'b0101; WVALID = 1'b1;
        tick;
        WVALID = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) if (BVALID) seen = 1'b1; else tick;
        n_checks++; if (!seen) begin n_fail++; $display("FAIL bvalid_timeout: got none expected BVALID"); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (BVALID !== 1'b1 || AWREADY !== 1'b0) begin n_fail++; $display("FAIL bvalid_hold%0d: got bvalid=%b awready=%b expected 1/0", k, BVALID, AWREADY); end
            tick;
        end
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        n_checks++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin n_fail++; $display("FAIL bvalid_drop: got bvalid=%b awready=%b expected 0/1", BVALID, AWREADY); end
        do_read(32'h4, d, r, lat);
        n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL strobe_merge: got %h expected 11bb33dd", d); end
        do_write(32'h4, 32'hFFFFFFFF, 4'h0, r, ok);
        n_checks++; if (!ok || r !== 2'b00) begin n_fail++; $display("FAIL zero_strb_resp: got done=%0d resp=%b expected done=1 resp=00", ok, r); end
        do_read(32'h4, d, r, lat);
        n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL zero_strb_data: got %h expected 11bb33dd", d); end
    endtask

    task automatic test_backpressure;
        bit go;
        go = 1'b0;
        ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
        for (int i = 0; i < 10 && !go; i++) begin
            go = ARREADY;
            tick;
        end
        ARADDR = 32'h8;
        for (int i = 0; i < 10 && !RVALID; i++) tick;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (RVALID !== 1'b1 || RDATA !== 32'h11BB33DD || ARREADY !== 1'b0) begin n_fail++; $display("FAIL r_hold%0d: got rvalid=%b rdata=%h arready=%b expected 1/11bb33dd/0", k, RVALID, RDATA, ARREADY); end
            tick;
        end
        RREADY = 1'b1;
        tick;
        n_checks++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin n_fail++; $display("FAIL ar_after_r: got arready=%b rvalid=%b expected 1/0", ARREADY, RVALID); end
        tick;
        ARVALID = 1'b0;
        n_checks++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL ar_accepted: got arready=%b expected 0", ARREADY); end
        for (int i = 0; i < 10 && !RVALID; i++) tick;
        n_checks++; if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL second_read: got rvalid=%b rdata=%h expected 1/deadbeef", RVALID, RDATA); end
        tick;
        RREADY = 1'b0;
    endtask

    task automatic test_collision;
        logic [31:0] d, rd;
        logic [1:0] r;
        bit ok, got_r, got_b;
        int lat;
        do_write(32'h1C, 32'hAAAAAAAA, 4'hF, r, ok);
        ARADDR = 32'h1C; ARVALID = 1'b1; RREADY = 1'b1;
        tick;
        ARVALID = 1'b0;
        AWADDR = 32'h1C; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        got_r = 1'b0; got_b = 1'b0; rd = 'x;
        for (int i = 0; i < 12 && !(got_r && got_b); i++) begin
            if (RVALID && !got_r) begin
                got_r = 1'b1;
                rd = RDATA;
            end
            if (BVALID) got_b = 1'b1;
            tick;
        end
        RREADY = 1'b0; BREADY = 1'b0;
        n_checks++; if (!got_r || rd !== 32'h55) begin n_fail++; $display("FAIL collision_rdata: got %h expected 00000055", rd); end
        n_checks++; if (!got_b) begin n_fail++; $display("FAIL collision_bvalid: got none expected BVALID"); end
        do_read(32'h1C, d, r, lat);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL collision_mem: got %h expected 00000055", d); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d, exp_d, exp_mem0;
        logic [1:0] r, exp_r;
        bit ok;
        int lat;
        do_write(32'h0, 32'h0BADF00D, 4'hF, r, ok);
`ifdef AXI_SRAM_SLVERR_EN
        exp_d = 32'h0; exp_r = 2'b10; exp_mem0 = 32'h0BADF00D;
`else
        exp_d = 32'h0BADF00D; exp_r = 2'b00; exp_mem0 = 32'h12345678;
`endif
        do_read(DEPTH * 4, d, r, lat);
        n_checks++; if (d !== exp_d || r !== exp_r) begin n_fail++; $display("FAIL oor_read: got %h/%b expected %h/%b", d, r, exp_d, exp_r); end
        n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL oor_latency: got %0d expected %0d", lat, LAT + 1); end
        do_write(DEPTH * 4, 32'h12345678, 4'hF, r, ok);
        n_checks++; if (!ok || r !== exp_r) begin n_fail++; $display("FAIL oor_bresp: got done=%0d resp=%b expected done=1 resp=%b", ok, r, exp_r); end
        do_read(32'h0, d, r, lat);
        n_checks++; if (d !== exp_mem0) begin n_fail++; $display("FAIL oor_write_effect: got %h expected %h", d, exp_mem0); end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] d;
        logic [1:0] r;
        int lat;
        ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b1;
        tick;
        ARVALID = 1'b0;
        tick;
        ARESETn = 1'b0;
        #1;
        n_checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin n_fail++; $display("FAIL async_reset: got rvalid=%b arready=%b expected 0/1", RVALID, ARREADY); end
        tick;
        ARESETn = 1'b1;
        tick;
        n_checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin n_fail++; $display("FAIL post_reset: got rvalid=%b arready=%b expected 0/1", RVALID, ARREADY); end
        do_read(32'h8, d, r, lat);
        n_checks++; if (d !== 32'hDEADBEEF || lat !== LAT + 1) begin n_fail++; $display("FAIL read_after_reset: got %h lat %0d expected deadbeef lat %0d", d, lat, LAT + 1); end
    endtask

    initial begin
        test_reset;
        test_read_latency;
        test_write_strobe;
        test_backpressure;
        test_collision;
        test_out_of_range;
        test_reset_in_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
